spi_responder: RTL

- Peripheral (target) end of the 4-wire sensor SPI link (CS, SPC, SDI, SDO), mode 3: SPC idles high, data changes on the falling edge and is sampled on the rising edge.
- Lets the design emulate a sensor register bank: decodes 16-bit frames from the bus initiator and issues register read/write strobes to a local register file.
- On reads, serialises the register data back on SDO.
- Oversampled design: SPC, CS and SDI are synchronised into clk. clk must run at ≥8× the SPC frequency.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_responder_if.sv | 26 ++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: frame geometry, FSM states, R/W encoding.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    HOLD
  } state_e;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned FRAME_BITS = 16;
  localparam logic        RW_READ    = 1'b1;

endpackage

// File: rtl/spi_responder_if.sv
// SPI pins plus the local register-file strobe bus of the responder.
interface spi_responder_if;

  logic       CS;
  logic       SPC;
  logic       SDI;
  logic       SDO;
  logic       sdo_oe;
  logic [6:0] reg_addr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       busy;

  modport slave (
    input  CS, SPC, SDI, reg_rdata,
    output SDO, sdo_oe, reg_addr, reg_rd, reg_wr, reg_wdata, busy
  );

  modport master (
    output CS, SPC, SDI, reg_rdata,
    input  SDO, sdo_oe, reg_addr, reg_rd, reg_wr, reg_wdata, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchroniser with rise/fall pulses taken from the last synchronised stage.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_responder.sv
// Mode-3 SPI target that decodes 16-bit frames into register read/write strobes.
// Optional burst continuation with address auto-increment: SPI_RESPONDER_AUTO_INC_EN.
module spi_responder
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        SDO_IDLE    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  spi_responder_if.slave  bus
);

  localparam logic [4:0] CmdLast   = 5'(CMD_BITS - 1);
  localparam logic [4:0] CmdBits   = 5'(CMD_BITS);
  localparam logic [4:0] FrameLast = 5'(FRAME_BITS - 1);
  localparam logic [4:0] FrameBits = 5'(FRAME_BITS);

  logic spc_s, spc_rise, spc_fall;
  logic cs_s, cs_rise, cs_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_spc (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (bus.SPC),
    .q_o    (spc_s),
    .rise_o (spc_rise),
    .fall_o (spc_fall)
  );

  // Resetting low means a CS already held low across reset is not seen as a new frame start.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (bus.CS),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (bus.SDI),
    .q_o    (sdi_s),
    .rise_o (sdi_rise),
    .fall_o (sdi_fall)
  );

  state_e     state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] cmd_sr_q, cmd_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_rd_q, reg_rd_d;
  logic       reg_wr_q, reg_wr_d;
  logic       load_q, load_d;
  logic       rw_q, rw_d;
  logic       sdo_oe_q, sdo_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] cmd_next, rx_next;
`ifdef SPI_RESPONDER_AUTO_INC_EN
  logic       inc_pend_q, inc_pend_d;
`endif

  logic unused_sigs;
  assign unused_sigs = ^{spc_s, cs_s, sdi_rise, sdi_fall, cmd_sr_q[7], rx_sr_q[7]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_rd_d    = 1'b0;
    reg_wr_d    = 1'b0;
    load_d      = reg_rd_q;
    rw_d        = rw_q;
    sdo_oe_d    = sdo_oe_q;
    busy_d      = busy_q;
    cmd_next    = {cmd_sr_q[6:0], sdi_s};
    rx_next     = {rx_sr_q[6:0], sdi_s};
`ifdef SPI_RESPONDER_AUTO_INC_EN
    inc_pend_d  = 1'b0;
    if (inc_pend_q) begin
      reg_addr_d = reg_addr_q + 7'd1;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      CMD: begin
        if (spc_rise) begin
          cmd_sr_d  = cmd_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == CmdLast) begin
            reg_addr_d = cmd_next[6:0];
            rw_d       = cmd_next[7];
            reg_rd_d   = (cmd_next[7] == RW_READ);
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        // The fall right after the 8th rise precedes the first data bit and must not shift.
        if (load_q) begin
          tx_sr_d  = bus.reg_rdata;
          sdo_oe_d = 1'b1;
        end else if (spc_fall && rw_q == RW_READ && bit_cnt_q > CmdBits) begin
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
        if (spc_rise) begin
          if (bit_cnt_q < FrameBits) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (rw_q != RW_READ) begin
            rx_sr_d = rx_next;
          end
          if (bit_cnt_q == FrameLast) begin
            if (rw_q != RW_READ) begin
              reg_wr_d    = 1'b1;
              reg_wdata_d = rx_next;
            end
`ifdef SPI_RESPONDER_AUTO_INC_EN
            bit_cnt_d = CmdBits;
            if (rw_q == RW_READ) begin
              reg_addr_d = reg_addr_q + 7'd1;
              reg_rd_d   = 1'b1;
            end else begin
              inc_pend_d = 1'b1;
            end
`else
            state_d  = HOLD;
            sdo_oe_d = 1'b0;
`endif
          end
        end
      end
      HOLD: begin
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sdo_oe_d = 1'b0;
      reg_rd_d = 1'b0;
      reg_wr_d = 1'b0;
      load_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      load_q      <= 1'b0;
      rw_q        <= 1'b0;
      sdo_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_rd_q    <= reg_rd_d;
      reg_wr_q    <= reg_wr_d;
      load_q      <= load_d;
      rw_q        <= rw_d;
      sdo_oe_q    <= sdo_oe_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SPI_RESPONDER_AUTO_INC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_pend_q <= 1'b0;
    end else begin
      inc_pend_q <= inc_pend_d;
    end
  end
`endif

  assign bus.SDO       = sdo_oe_q ? tx_sr_q[7] : SDO_IDLE;
  assign bus.sdo_oe    = sdo_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.busy      = busy_q;

endmodule
